min_sad_tracker: RTL and testbench
==================================

# min_sad_tracker

Downstream consumer of the 11×11 pixel-difference sum stage:
- Receives one window sum per candidate position as the frame is rasterised.
- Tracks the minimum sum and its window-centre coordinates across the frame.
- At end of frame, publishes the best match plus found/lost status to the game-control logic (player ship position from camera).
- Sits between the window-sum adder and the ship-position register in the video path.

## Interface
Parameters:
- SUM_W, 16, width of incoming window sum (max 121×255 = 30855 fits)
- COORD_W, 10, width of x/y coordinates
- THRESH, 16'd6000, a frame minimum strictly below this counts as "found"
- LOST_FRAMES, 4, consecutive not-found frames before `lost` asserts (1..15)

Ports:
- clk  in  1  pixel clock, sole clock
- rst  in  1  synchronous, active-high reset
- sof  in  1  start-of-frame pulse, one cycle
- eof  in  1  end-of-frame pulse, one cycle
- sum_valid  in  1  `soma`/`x`/`y` valid this cycle
- soma  in  SUM_W  window sum for current candidate
- x  in  COORD_W  window-centre column
- y  in  COORD_W  window-centre row
- best_x  out  COORD_W  column of last published minimum
- best_y  out  COORD_W  row of last published minimum
- best_soma  out  SUM_W  last published minimum sum
- found  out  1  last published frame had minimum < THRESH
- lost  out  1  LOST_FRAMES consecutive frames not found
- result_valid  out  1  one-cycle pulse when outputs update

## Operation
- States:
  - IDLE: after reset; ignores `sum_valid`.
  - SCAN: entered on `sof`.
  - PUBLISH: entered from SCAN on `eof`; stays one cycle, then returns to IDLE.
- On `sof` (any state):
  - Load the running minimum with all-ones, clear the `seen` flag, go to SCAN.
- In SCAN, when `sum_valid` is high:
  - If `soma` < running minimum, load `soma`, `x` and `y` into the running registers and set `seen`.
  - Ties keep the earlier candidate (raster order): the compare is strict less-than.
- Same-cycle `sof` and `sum_valid`: clear first, then compare against the cleared minimum, so the sample counts as the first of the new frame.
- Same-cycle `eof` and `sum_valid` in SCAN: the sample is included before publishing.
- PUBLISH:
  - Copy running minimum/coordinates to `best_*`.
  - `found` = `seen` AND minimum < THRESH.
  - Pulse `result_valid`.
- If `seen` = 0 at publish (no samples in the frame):
  - `best_x`/`best_y`/`best_soma` hold their previous values.
  - `found` = 0.
  - `result_valid` still pulses.
- Miss counter (4 bits):
  - Clears when a published `found` = 1.
  - Otherwise increments, saturating at 15.
  - `lost` = (miss counter ≥ LOST_FRAMES), updated in the same cycle as `best_*`.
- `eof` in IDLE is ignored: no publish, no miss count.
- `sof` while in SCAN restarts the scan and discards the partial frame; no publish.
- Reset mid-scan discards all running state; outputs return to reset values.

## Timing
- Reset values:
  - `best_x`, `best_y` = 0; `best_soma` = all-ones.
  - `found` = 0, `lost` = 0, `result_valid` = 0.
  - Miss counter = 0, state IDLE.
- Compare-and-update is single-cycle: the running minimum reflects a sample on the clock edge after `sum_valid`.
- `eof` at edge N → state PUBLISH for cycle N+1 → `result_valid` high and `best_*`/`found`/`lost` updated at edge N+2.
- Outputs are stable until the next publish.
- No backpressure: `sum_valid` may be high every cycle.
- Throughput is one sample per clock.
- Inputs are sampled only on `clk` rising edges.

## Structure
- Shared package holds:
  - `tracker_state_t` enum (IDLE, SCAN, PUBLISH).
  - SUM_W/COORD_W defaults.
  - `SUM_MAX` constant 16'hFFFF, shared with the adder stage.
- One natural sub-module, `min_sample_reg`:
  - Running minimum + coordinate registers with strict-less-than compare.
  - Clear input with priority as above.
- The FSM and miss counter stay in the top.

## Test plan
- Single frame, 3 samples:
  - Stimulus: `sof`; samples (x=10,y=5,s=900), (x=20,y=5,s=400), (x=30,y=5,s=700); `eof`.
  - Required: `result_valid` pulse 2 cycles after `eof`; `best_x`=20, `best_y`=5, `best_soma`=400, `found`=1, `lost`=0.
- Tie:
  - Stimulus: samples s=500 at x=7 then s=500 at x=9.
  - Required: `best_x`=7.
- Above threshold:
  - Stimulus: minimum 7000 for 4 consecutive frames.
  - Required: `found`=0 each frame; `lost` rises on the 4th publish.
  - Then a frame with minimum 100: `found`=1, `lost`=0.
- Empty frame:
  - Stimulus: `sof` then `eof` with no `sum_valid`, following a valid frame.
  - Required: `best_*` unchanged; `found`=0; `result_valid` pulses.
- Boundary events:
  - `sof` coincident with a s=50 sample: that sample wins the frame.
  - `eof` coincident with a s=10 sample: `best_soma`=10.
  - `sof` mid-scan: no publish.
- Reset mid-scan:
  - Stimulus: assert `rst` mid-scan, then `eof`.
  - Required: all outputs at reset values; no `result_valid`, since the state is IDLE.

Source files
------------

// File: rtl/min_sad_tracker_pkg.sv
// -----------------------------------------------------------------------------
// min_sad_tracker_pkg
// Shared types and constants for the minimum-SAD tracker and its neighbours in
// the video path (the window-sum adder also uses SUM_MAX).
//   tracker_state_t : frame FSM states
//   SUM_W_DEF       : default window-sum width
//   COORD_W_DEF     : default coordinate width
//   SUM_MAX         : all-ones window sum, the "no candidate yet" value
//   sat_inc4        : 4-bit saturating increment used by the miss counter
// -----------------------------------------------------------------------------
package min_sad_tracker_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SCAN    = 2'd1,
      PUBLISH = 2'd2
   } tracker_state_t;

   localparam int          SUM_W_DEF   = 16;
   localparam int          COORD_W_DEF = 10;
   localparam logic [15:0] SUM_MAX     = 16'hFFFF;

   function automatic logic [3:0] sat_inc4(input logic [3:0] val);
      logic [3:0] res;
      if (val == 4'd15) begin
         res = 4'd15;
      end else begin
         res = val + 4'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/min_sad_tracker_if.sv
// -----------------------------------------------------------------------------
// min_sad_tracker_if
// Bundles the sample stream from the window-sum adder and the per-frame result
// towards game control.
//   master : sample source / result consumer (drives sof, eof, sum_valid,
//            soma, x, y; reads best_x, best_y, best_soma, found, lost,
//            result_valid)
//   slave  : the tracker (the opposite directions)
// -----------------------------------------------------------------------------
interface min_sad_tracker_if
   import min_sad_tracker_pkg::*;
#(
   parameter int SUM_W   = SUM_W_DEF,
   parameter int COORD_W = COORD_W_DEF
);
   logic               sof;
   logic               eof;
   logic               sum_valid;
   logic [SUM_W-1:0]   soma;
   logic [COORD_W-1:0] x;
   logic [COORD_W-1:0] y;
   logic [COORD_W-1:0] best_x;
   logic [COORD_W-1:0] best_y;
   logic [SUM_W-1:0]   best_soma;
   logic               found;
   logic               lost;
   logic               result_valid;

   modport master (
      output sof, eof, sum_valid, soma, x, y,
      input  best_x, best_y, best_soma, found, lost, result_valid
   );

   modport slave (
      input  sof, eof, sum_valid, soma, x, y,
      output best_x, best_y, best_soma, found, lost, result_valid
   );
endinterface

// File: rtl/min_sad_tracker_min_sample_reg.sv
// -----------------------------------------------------------------------------
// min_sample_reg
// Running minimum of the window sums within a frame plus the coordinates of
// the sample that produced it. A clear in the same cycle as a sample acts
// first, so that sample is compared against the freshly cleared minimum.
//   clk, rst     : pixel clock, synchronous active-high reset
//   clr_i        : restart the frame (minimum to all-ones, seen cleared)
//   sample_en_i  : a sample is offered for comparison this cycle
//   soma_i/x_i/y_i : the sample and its window centre
//   min_o/x_o/y_o  : current running minimum and its coordinates
//   seen_o       : at least one sample was taken since the last clear
// -----------------------------------------------------------------------------
module min_sample_reg
   import min_sad_tracker_pkg::*;
#(
   parameter int SUM_W   = SUM_W_DEF,
   parameter int COORD_W = COORD_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr_i,
   input  logic               sample_en_i,
   input  logic [SUM_W-1:0]   soma_i,
   input  logic [COORD_W-1:0] x_i,
   input  logic [COORD_W-1:0] y_i,
   output logic [SUM_W-1:0]   min_o,
   output logic [COORD_W-1:0] x_o,
   output logic [COORD_W-1:0] y_o,
   output logic               seen_o
);
   logic [SUM_W-1:0]   min_q, min_d, base_min_s;
   logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
   logic               seen_q, seen_d, base_seen_s, take_s;

   // Clear-then-compare; strict less-than keeps the earlier sample on ties.
   always_comb begin
      base_min_s  = min_q;
      base_seen_s = seen_q;
      min_d       = min_q;
      x_d         = x_q;
      y_d         = y_q;
      seen_d      = seen_q;
      if (clr_i) begin
         base_min_s  = {SUM_W{1'b1}};
         base_seen_s = 1'b0;
      end else begin
         base_min_s  = min_q;
         base_seen_s = seen_q;
      end
      take_s = sample_en_i && (soma_i < base_min_s);
      if (take_s) begin
         min_d  = soma_i;
         x_d    = x_i;
         y_d    = y_i;
         seen_d = 1'b1;
      end else begin
         min_d  = base_min_s;
         x_d    = x_q;
         y_d    = y_q;
         seen_d = base_seen_s;
      end
   end

   // Running minimum and coordinate registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         min_q  <= {SUM_W{1'b1}};
         x_q    <= {COORD_W{1'b0}};
         y_q    <= {COORD_W{1'b0}};
         seen_q <= 1'b0;
      end else begin
         min_q  <= min_d;
         x_q    <= x_d;
         y_q    <= y_d;
         seen_q <= seen_d;
      end
   end

   assign min_o  = min_q;
   assign x_o    = x_q;
   assign y_o    = y_q;
   assign seen_o = seen_q;
endmodule

// File: rtl/min_sad_tracker.sv
// -----------------------------------------------------------------------------
// min_sad_tracker
// Tracks the smallest window sum of each frame and, one cycle after the frame
// ends, publishes its position with found/lost status for the ship-position
// logic.
//   clk, rst : pixel clock, synchronous active-high reset
//   bus      : min_sad_tracker_if.slave (sample stream in, frame result out)
// -----------------------------------------------------------------------------
module min_sad_tracker
   import min_sad_tracker_pkg::*;
#(
   parameter int               SUM_W       = SUM_W_DEF,
   parameter int               COORD_W     = COORD_W_DEF,
   parameter logic [SUM_W-1:0] THRESH      = 16'd6000,
   parameter int               LOST_FRAMES = 4
) (
   input logic              clk,
   input logic              rst,
   min_sad_tracker_if.slave bus
);
   localparam logic [3:0] LOST_TH = 4'(LOST_FRAMES);

   tracker_state_t     state_q, state_d;
   logic               sample_en_s;
   logic [SUM_W-1:0]   run_min_s;
   logic [COORD_W-1:0] run_x_s, run_y_s;
   logic               run_seen_s;

   logic [COORD_W-1:0] best_x_q, best_x_d, best_y_q, best_y_d;
   logic [SUM_W-1:0]   best_soma_q, best_soma_d;
   logic               found_q, found_d, lost_q, lost_d;
   logic               result_valid_q, result_valid_d;
   logic [3:0]         miss_q, miss_d;

   // A sample coinciding with sof belongs to the new frame, even from IDLE.
   assign sample_en_s = bus.sum_valid && (bus.sof || (state_q == SCAN));

   min_sample_reg #(
      .SUM_W   (SUM_W),
      .COORD_W (COORD_W)
   ) u_min_sample_reg (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (bus.sof),
      .sample_en_i (sample_en_s),
      .soma_i      (bus.soma),
      .x_i         (bus.x),
      .y_i         (bus.y),
      .min_o       (run_min_s),
      .x_o         (run_x_s),
      .y_o         (run_y_s),
      .seen_o      (run_seen_s)
   );

   // Frame FSM next state; sof restarts the scan from any state.
   always_comb begin
      state_d = state_q;
      if (bus.sof) begin
         state_d = SCAN;
      end else begin
         case (state_q)
            IDLE:    state_d = IDLE;
            SCAN: begin
               if (bus.eof) begin
                  state_d = PUBLISH;
               end else begin
                  state_d = SCAN;
               end
            end
            PUBLISH: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Frame FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Result and miss-counter update during the single PUBLISH cycle.
   always_comb begin
      best_x_d       = best_x_q;
      best_y_d       = best_y_q;
      best_soma_d    = best_soma_q;
      found_d        = found_q;
      lost_d         = lost_q;
      miss_d         = miss_q;
      result_valid_d = 1'b0;
      if (state_q == PUBLISH) begin
         result_valid_d = 1'b1;
         found_d        = run_seen_s && (run_min_s < THRESH);
         // An empty frame leaves the previous best in place.
         if (run_seen_s) begin
            best_x_d    = run_x_s;
            best_y_d    = run_y_s;
            best_soma_d = run_min_s;
         end else begin
            best_x_d    = best_x_q;
            best_y_d    = best_y_q;
            best_soma_d = best_soma_q;
         end
         if (found_d) begin
            miss_d = 4'd0;
         end else begin
            miss_d = sat_inc4(miss_q);
         end
         lost_d = (miss_d >= LOST_TH);
      end else begin
         result_valid_d = 1'b0;
      end
   end

   // Published result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         best_x_q       <= {COORD_W{1'b0}};
         best_y_q       <= {COORD_W{1'b0}};
         best_soma_q    <= {SUM_W{1'b1}};
         found_q        <= 1'b0;
         lost_q         <= 1'b0;
         result_valid_q <= 1'b0;
         miss_q         <= 4'd0;
      end else begin
         best_x_q       <= best_x_d;
         best_y_q       <= best_y_d;
         best_soma_q    <= best_soma_d;
         found_q        <= found_d;
         lost_q         <= lost_d;
         result_valid_q <= result_valid_d;
         miss_q         <= miss_d;
      end
   end

   assign bus.best_x       = best_x_q;
   assign bus.best_y       = best_y_q;
   assign bus.best_soma    = best_soma_q;
   assign bus.found        = found_q;
   assign bus.lost         = lost_q;
   assign bus.result_valid = result_valid_q;
endmodule

// File: tb/tb_min_sad_tracker.sv
// -----------------------------------------------------------------------------
// tb_min_sad_tracker
// Frame table plus hand-written boundary sequences for min_sad_tracker.
// Expected results are queued when a frame's eof is driven and compared when
// result_valid pulses.
// -----------------------------------------------------------------------------
module tb_min_sad_tracker;
   logic clk;
   logic rst;

   min_sad_tracker_if #(.SUM_W(16), .COORD_W(10)) bus ();

   min_sad_tracker #(
      .SUM_W       (16),
      .COORD_W     (10),
      .THRESH      (16'd6000),
      .LOST_FRAMES (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [9:0]  bx;
      logic [9:0]  by;
      logic [15:0] bs;
      logic        found;
      logic        lost;
   } exp_t;

   typedef struct {
      int               n;
      logic [2:0][9:0]  sx;
      logic [2:0][9:0]  sy;
      logic [2:0][15:0] ss;
      exp_t             e;
   } frame_t;

   exp_t   exp_q[$];
   frame_t tbl[11];
   int     n_checks = 0;
   int     n_pass   = 0;
   int     pulses   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic frame_t mk(input int n,
                                 input int x0, input int y0, input int s0,
                                 input int x1, input int y1, input int s1,
                                 input int x2, input int y2, input int s2,
                                 input int ex, input int ey, input int es,
                                 input int ef, input int el);
      frame_t f;
      f.n     = n;
      f.sx[0] = 10'(x0); f.sy[0] = 10'(y0); f.ss[0] = 16'(s0);
      f.sx[1] = 10'(x1); f.sy[1] = 10'(y1); f.ss[1] = 16'(s1);
      f.sx[2] = 10'(x2); f.sy[2] = 10'(y2); f.ss[2] = 16'(s2);
      f.e.bx    = 10'(ex);
      f.e.by    = 10'(ey);
      f.e.bs    = 16'(es);
      f.e.found = 1'(ef);
      f.e.lost  = 1'(el);
      return f;
   endfunction

   task automatic drive(input bit s, input bit e, input bit v,
                        input int xx, input int yy, input int ss);
      bus.sof       = s;
      bus.eof       = e;
      bus.sum_valid = v;
      bus.x         = 10'(xx);
      bus.y         = 10'(yy);
      bus.soma      = 16'(ss);
      @(posedge clk);
      #1;
      bus.sof       = 1'b0;
      bus.eof       = 1'b0;
      bus.sum_valid = 1'b0;
   endtask

   // Called right after the eof cycle; the pulse is due two edges after eof.
   task automatic wait_publish();
      int lat;
      lat = 99;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (bus.result_valid) begin
            lat = k;
            break;
         end
      end
      chk("publish_latency", 32'(lat), 32'd2);
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input frame_t f);
      drive(1'b1, 1'b0, 1'b0, 0, 0, 0);
      for (int i = 0; i < f.n; i++) begin
         drive(1'b0, 1'b0, 1'b1, int'(f.sx[i]), int'(f.sy[i]), int'(f.ss[i]));
      end
      exp_q.push_back(f.e);
      drive(1'b0, 1'b1, 1'b0, 0, 0, 0);
      wait_publish();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_best_x"},    32'(bus.best_x),       32'd0);
      chk({tag, "_best_y"},    32'(bus.best_y),       32'd0);
      chk({tag, "_best_soma"}, 32'(bus.best_soma),    32'hFFFF);
      chk({tag, "_found"},     32'(bus.found),        32'd0);
      chk({tag, "_lost"},      32'(bus.lost),         32'd0);
      chk({tag, "_rvalid"},    32'(bus.result_valid), 32'd0);
   endtask

   // Scoreboard: every result_valid pulse must match the oldest queued frame.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.result_valid) begin
         pulses++;
         if (exp_q.size() == 0) begin
            chk("unexpected_result_valid", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("best_x",    32'(bus.best_x),    32'(e.bx));
            chk("best_y",    32'(bus.best_y),    32'(e.by));
            chk("best_soma", 32'(bus.best_soma), 32'(e.bs));
            chk("found",     32'(bus.found),     32'(e.found));
            chk("lost",      32'(bus.lost),      32'(e.lost));
         end
      end
   end

   initial begin
      int p0;
      int rv_cnt;

      // n, three samples (x,y,s), expected bx, by, bs, found, lost
      tbl[0]  = mk(3, 10,5,900,   20,5,400,  30,5,700, 20,5,400,   1,0);
      tbl[1]  = mk(2, 7,3,500,    9,3,500,   0,0,0,     7,3,500,    1,0);
      tbl[2]  = mk(2, 1,1,7000,   2,1,8000,  0,0,0,     1,1,7000,   0,0);
      tbl[3]  = mk(2, 1,1,7000,   2,1,8000,  0,0,0,     1,1,7000,   0,0);
      tbl[4]  = mk(2, 1,1,7000,   2,1,8000,  0,0,0,     1,1,7000,   0,0);
      tbl[5]  = mk(2, 1,1,7000,   2,1,8000,  0,0,0,     1,1,7000,   0,1);
      tbl[6]  = mk(1, 4,4,100,    0,0,0,     0,0,0,     4,4,100,    1,0);
      tbl[7]  = mk(0, 0,0,0,      0,0,0,     0,0,0,     4,4,100,    0,0);
      tbl[8]  = mk(1, 5,6,6000,   0,0,0,     0,0,0,     5,6,6000,   0,0);
      tbl[9]  = mk(1, 5,7,5999,   0,0,0,     0,0,0,     5,7,5999,   1,0);
      tbl[10] = mk(1, 6,6,65535,  0,0,0,     0,0,0,     5,7,5999,   0,0);

      rst           = 1'b1;
      bus.sof       = 1'b0;
      bus.eof       = 1'b0;
      bus.sum_valid = 1'b0;
      bus.x         = 10'd0;
      bus.y         = 10'd0;
      bus.soma      = 16'd0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_reset_outputs("reset");

      // eof while IDLE must not publish.
      drive(1'b0, 1'b1, 1'b0, 0, 0, 0);
      repeat (3) @(negedge clk);
      chk("idle_eof_pulses", 32'(pulses), 32'd0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 11; i++) begin
         run_frame(tbl[i]);
      end

      // Mid-scan sof discards the partial frame; a sample alongside sof wins.
      p0 = pulses;
      drive(1'b1, 1'b0, 1'b0, 0, 0, 0);
      drive(1'b0, 1'b0, 1'b1, 1, 2, 20);
      drive(1'b1, 1'b0, 1'b1, 11, 12, 50);
      drive(1'b0, 1'b0, 1'b1, 13, 12, 60);
      drive(1'b0, 1'b0, 1'b1, 15, 12, 50);
      exp_q.push_back('{bx: 10'd11, by: 10'd12, bs: 16'd50, found: 1'b1, lost: 1'b0});
      drive(1'b0, 1'b1, 1'b0, 0, 0, 0);
      wait_publish();
      chk("sof_restart_pulses", 32'(pulses - p0), 32'd1);

      // Sample alongside eof is part of the frame.
      drive(1'b1, 1'b0, 1'b0, 0, 0, 0);
      drive(1'b0, 1'b0, 1'b1, 3, 3, 200);
      exp_q.push_back('{bx: 10'd8, by: 10'd9, bs: 16'd10, found: 1'b1, lost: 1'b0});
      drive(1'b0, 1'b1, 1'b1, 8, 9, 10);
      wait_publish();

      // Build up three misses, then reset mid-scan.
      for (int i = 0; i < 3; i++) begin
         run_frame(tbl[2]);
      end
      drive(1'b1, 1'b0, 1'b0, 0, 0, 0);
      drive(1'b0, 1'b0, 1'b1, 3, 3, 5);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      p0 = pulses;
      drive(1'b0, 1'b1, 1'b0, 0, 0, 0);
      rv_cnt = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (bus.result_valid) rv_cnt++;
      end
      chk("reset_mid_scan_pulses", 32'(rv_cnt), 32'd0);
      chk_reset_outputs("after_reset");
      @(posedge clk);
      #1;

      // Miss counter restarted from zero: lost only on the fourth bad frame.
      run_frame(tbl[2]);
      run_frame(tbl[3]);
      run_frame(tbl[4]);
      run_frame(tbl[5]);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
